// File: rtl/window_invoke_fsm1_if.sv
// Handshake and FIFO-status bundle between a dataflow scheduler and the
// window_invoke_fsm1 actor-invocation controller.
interface window_invoke_fsm1_if #(
   parameter int pw = 5
);
   logic          invoke;
   logic [pw-1:0] pop_data;
   logic [pw-1:0] pop_length;
   logic [pw-1:0] pop_command;
   logic [pw-1:0] free_out;
   logic [1:0]    length_in;
   logic [1:0]    command_in;
   logic          done_in;
   logic          enable_out;
   logic          busy_out;
   logic          start_out;
   logic [1:0]    next_mode_out;
   logic          rd_length_fifo;
   logic          rd_command_fifo;
   logic [1:0]    length_out;
   logic [1:0]    command_out;
   logic          firing_done_out;
   logic [15:0]   fire_count_out;

   modport master (
      output invoke, pop_data, pop_length, pop_command, free_out,
             length_in, command_in, done_in,
      input  enable_out, busy_out, start_out, next_mode_out,
             rd_length_fifo, rd_command_fifo, length_out, command_out,
             firing_done_out, fire_count_out
   );

   modport slave (
      input  invoke, pop_data, pop_length, pop_command, free_out,
             length_in, command_in, done_in,
      output enable_out, busy_out, start_out, next_mode_out,
             rd_length_fifo, rd_command_fifo, length_out, command_out,
             firing_done_out, fire_count_out
   );
endinterface

// File: rtl/window_invoke_fsm1.sv
// Level-1 invocation FSM for a three-mode windowed actor: checks the firing
// condition of the current mode, launches the level-2 firing and tracks completions.
module window_invoke_fsm1 #(
   parameter int unsigned size        = 3,
   parameter int unsigned width       = 10,
   parameter int unsigned buffer_size = 16
) (
   input logic             clk,
   input logic             rst,
   window_invoke_fsm1_if.slave bus
);

   localparam logic [1:0] MODE_SETUP  = 2'b00;
   localparam logic [1:0] MODE_COMP   = 2'b01;
   localparam logic [1:0] MODE_OUTPUT = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      FIRE_START,
      FIRE_WAIT,
      UPDATE
   } state_t;

   state_t      state;
   logic [1:0]  mode;
   logic [1:0]  length_q;
   logic [1:0]  command_q;
   logic [15:0] fire_count;
   logic        start_q;
   logic        rd_q;
   logic        firing_done_q;
   logic        busy_q;
   logic        is_setup;
   logic        enable;
   logic [1:0]  mode_next;

   if (width < 1 || size < 1 || size > buffer_size) begin : g_bad_params
      $error("window_invoke_fsm1: size must be 1..buffer_size and width >= 1");
   end

   // The unused encoding 2'b11 behaves exactly like SETUP_COMP.
   assign is_setup = (mode == MODE_SETUP) || (mode == 2'b11);

   always_comb begin
      enable = 1'b0;
      if (is_setup) begin
         enable = (32'(bus.pop_data) >= size) && (bus.pop_length != '0) &&
                  (bus.pop_command != '0);
      end else if (mode == MODE_COMP) begin
         enable = 1'b1;
      end else begin
         enable = (bus.free_out != '0);
      end
   end

   always_comb begin
      mode_next = MODE_COMP;
      case (mode)
         MODE_COMP:   mode_next = MODE_OUTPUT;
         MODE_OUTPUT: mode_next = MODE_SETUP;
         default:     mode_next = MODE_COMP;
      endcase
   end

   // Pulse outputs are registered on the transition into their state so they
   // line up exactly with the state they belong to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         mode          <= MODE_SETUP;
         length_q      <= 2'b00;
         command_q     <= 2'b00;
         fire_count    <= 16'h0000;
         start_q       <= 1'b0;
         rd_q          <= 1'b0;
         firing_done_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.invoke && enable) begin
                  state   <= FIRE_START;
                  start_q <= 1'b1;
                  rd_q    <= is_setup;
                  busy_q  <= 1'b1;
               end
            end
            FIRE_START: begin
               state   <= FIRE_WAIT;
               start_q <= 1'b0;
               rd_q    <= 1'b0;
               if (is_setup) begin
                  length_q  <= bus.length_in;
                  command_q <= bus.command_in;
               end
            end
            FIRE_WAIT: begin
               if (bus.done_in) begin
                  state         <= UPDATE;
                  firing_done_q <= 1'b1;
               end
            end
            UPDATE: begin
               state         <= IDLE;
               firing_done_q <= 1'b0;
               busy_q        <= 1'b0;
               fire_count    <= fire_count + 16'd1;
               mode          <= mode_next;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.enable_out      = (state == IDLE) && enable;
   assign bus.busy_out        = busy_q;
   assign bus.start_out       = start_q;
   assign bus.next_mode_out   = mode;
   assign bus.rd_length_fifo  = rd_q;
   assign bus.rd_command_fifo = rd_q;
   assign bus.length_out      = length_q;
   assign bus.command_out     = command_q;
   assign bus.firing_done_out = firing_done_q;
   assign bus.fire_count_out  = fire_count;

endmodule

// File: tb/tb_window_invoke_fsm1.sv
// Self-checking bench for window_invoke_fsm1: enable-condition table plus
// multi-cycle firing sequences, with start pulses checked against a scoreboard.
module tb_window_invoke_fsm1;

   localparam int PW = $clog2(16) + 1;

   typedef struct {
      logic [PW-1:0] pop_data;
      logic [PW-1:0] pop_length;
      logic [PW-1:0] pop_command;
      logic [PW-1:0] free_out;
      logic          exp_enable;
   } vec_t;

   typedef struct {
      logic [1:0] mode;
      logic       rd;
   } sb_t;

   logic  clk = 1'b0;
   logic  rst;
   int    testCount = 0;
   int    failCount = 0;
   int    expCount  = 0;
   sb_t   sbQ[$];
   vec_t  vecs[7];

   window_invoke_fsm1_if #(.pw(PW)) bus_if ();

   window_invoke_fsm1 #(.size(3), .width(10), .buffer_size(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus_if.pop_data    = v.pop_data;
      bus_if.pop_length  = v.pop_length;
      bus_if.pop_command = v.pop_command;
      bus_if.free_out    = v.free_out;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every start pulse must match the oldest firing the bench launched.
   always begin : monitor
      sb_t e;
      @(posedge clk);
      #1;
      if (bus_if.start_out === 1'b1) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_start", bus_if.start_out, 32'd0);
         end else begin
            e = sbQ.pop_front();
            checkOutput("start_mode", bus_if.next_mode_out, e.mode);
            checkOutput("start_rd_length", bus_if.rd_length_fifo, e.rd);
            checkOutput("start_rd_command", bus_if.rd_command_fifo, e.rd);
         end
      end
   end

   task automatic fireOnce(input logic [1:0] mode);
      bit seen;
      sbQ.push_back('{mode: mode, rd: (mode == 2'b00)});
      bus_if.invoke = 1'b1;
      tick();
      bus_if.invoke = 1'b0;
      checkOutput("busy_during_firing", bus_if.busy_out, 32'd1);
      checkOutput("enable_outside_idle", bus_if.enable_out, 32'd0);
      repeat (3) tick();
      bus_if.done_in = 1'b1;
      tick();
      bus_if.done_in = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus_if.firing_done_out === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      checkOutput("firing_done_pulse", seen, 32'd1);
      tick();
      expCount++;
      checkOutput("firing_done_one_cycle", bus_if.firing_done_out, 32'd0);
      checkOutput("idle_after_firing", bus_if.busy_out, 32'd0);
      checkOutput("fire_count", bus_if.fire_count_out, expCount);
      checkOutput("mode_advance", bus_if.next_mode_out,
                  (mode == 2'b10) ? 32'd0 : 32'(mode) + 32'd1);
   endtask

   initial begin
      int pulses;
      bus_if.invoke     = 1'b0;
      bus_if.done_in    = 1'b0;
      bus_if.length_in  = 2'd0;
      bus_if.command_in = 2'd0;
      applyStimulus('{pop_data: '0, pop_length: '0, pop_command: '0, free_out: '0,
                      exp_enable: 1'b0});
      rst = 1'b0;
      repeat (2) tick();

      checkOutput("reset_busy", bus_if.busy_out, 32'd0);
      checkOutput("reset_start", bus_if.start_out, 32'd0);
      checkOutput("reset_rd", {bus_if.rd_length_fifo, bus_if.rd_command_fifo}, 32'd0);
      checkOutput("reset_firing_done", bus_if.firing_done_out, 32'd0);
      checkOutput("reset_mode", bus_if.next_mode_out, 32'd0);
      checkOutput("reset_count", bus_if.fire_count_out, 32'd0);
      checkOutput("reset_length_cmd", {bus_if.length_out, bus_if.command_out}, 32'd0);
      rst = 1'b1;
      tick();

      // SETUP_COMP enable condition needs pop_data >= 3 and one length and command token.
      vecs[0] = '{pop_data: 5'd3,  pop_length: 5'd1,  pop_command: 5'd1,  free_out: 5'd0, exp_enable: 1'b1};
      vecs[1] = '{pop_data: 5'd2,  pop_length: 5'd1,  pop_command: 5'd1,  free_out: 5'd1, exp_enable: 1'b0};
      vecs[2] = '{pop_data: 5'd3,  pop_length: 5'd0,  pop_command: 5'd1,  free_out: 5'd1, exp_enable: 1'b0};
      vecs[3] = '{pop_data: 5'd3,  pop_length: 5'd1,  pop_command: 5'd0,  free_out: 5'd1, exp_enable: 1'b0};
      vecs[4] = '{pop_data: 5'd16, pop_length: 5'd16, pop_command: 5'd16, free_out: 5'd0, exp_enable: 1'b1};
      vecs[5] = '{pop_data: 5'd4,  pop_length: 5'd2,  pop_command: 5'd1,  free_out: 5'd0, exp_enable: 1'b1};
      vecs[6] = '{pop_data: 5'd0,  pop_length: 5'd0,  pop_command: 5'd0,  free_out: 5'd1, exp_enable: 1'b0};
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("enable_vec%0d", i), bus_if.enable_out, vecs[i].exp_enable);
      end
      tick();

      // Too few data tokens: invoke must be ignored.
      applyStimulus('{pop_data: 5'd2, pop_length: 5'd1, pop_command: 5'd1, free_out: 5'd1,
                      exp_enable: 1'b0});
      bus_if.invoke = 1'b1;
      tick();
      bus_if.invoke = 1'b0;
      checkOutput("setup_blocked_start", bus_if.start_out, 32'd0);
      checkOutput("setup_blocked_busy", bus_if.busy_out, 32'd0);

      applyStimulus('{pop_data: 5'd3, pop_length: 5'd1, pop_command: 5'd1, free_out: 5'd1,
                      exp_enable: 1'b1});
      bus_if.length_in  = 2'd2;
      bus_if.command_in = 2'd1;
      fireOnce(2'b00);
      checkOutput("captured_length", bus_if.length_out, 32'd2);
      checkOutput("captured_command", bus_if.command_out, 32'd1);

      bus_if.length_in  = 2'd3;
      bus_if.command_in = 2'd0;
      fireOnce(2'b01);
      checkOutput("length_held_comp", bus_if.length_out, 32'd2);
      checkOutput("command_held_comp", bus_if.command_out, 32'd1);

      // OUTPUT mode with a full output FIFO must not fire.
      bus_if.free_out = 5'd0;
      #1;
      checkOutput("output_enable_full", bus_if.enable_out, 32'd0);
      bus_if.invoke = 1'b1;
      tick();
      bus_if.invoke = 1'b0;
      checkOutput("output_blocked_start", bus_if.start_out, 32'd0);
      checkOutput("output_blocked_busy", bus_if.busy_out, 32'd0);
      bus_if.free_out = 5'd1;
      fireOnce(2'b10);
      checkOutput("length_held_output", bus_if.length_out, 32'd2);

      // Reset while waiting for done_in abandons the firing.
      sbQ.push_back('{mode: 2'b00, rd: 1'b1});
      bus_if.invoke = 1'b1;
      tick();
      bus_if.invoke = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      #1;
      expCount = 0;
      checkOutput("midreset_busy", bus_if.busy_out, 32'd0);
      checkOutput("midreset_mode", bus_if.next_mode_out, 32'd0);
      checkOutput("midreset_count", bus_if.fire_count_out, expCount);
      checkOutput("midreset_firing_done", bus_if.firing_done_out, 32'd0);
      checkOutput("midreset_length", bus_if.length_out, 32'd0);
      tick();
      rst = 1'b1;
      bus_if.done_in = 1'b1;
      tick();
      bus_if.done_in = 1'b0;
      checkOutput("late_done_ignored", bus_if.firing_done_out, 32'd0);
      checkOutput("late_done_busy", bus_if.busy_out, 32'd0);
      tick();
      checkOutput("late_done_count", bus_if.fire_count_out, expCount);

      // Counter wrap, with invoke and done_in held high across three firings.
      force dut.fire_count = 16'hFFFF;
      tick();
      release dut.fire_count;
      checkOutput("preload_count", bus_if.fire_count_out, 32'hFFFF);
      sbQ.push_back('{mode: 2'b00, rd: 1'b1});
      sbQ.push_back('{mode: 2'b01, rd: 1'b0});
      sbQ.push_back('{mode: 2'b10, rd: 1'b0});
      bus_if.invoke  = 1'b1;
      bus_if.done_in = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (bus_if.firing_done_out === 1'b1) pulses++;
         if (i == 4) checkOutput("count_wrap", bus_if.fire_count_out, 32'd0);
      end
      bus_if.invoke  = 1'b0;
      bus_if.done_in = 1'b0;
      checkOutput("held_done_pulses", pulses, 32'd3);
      checkOutput("held_final_count", bus_if.fire_count_out, 32'd2);
      checkOutput("held_final_mode", bus_if.next_mode_out, 32'd0);
      tick();
      checkOutput("scoreboard_drained", sbQ.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
